// File: rtl/flip_flop_d_pkg.sv
// Shared constants for the flip_flop_d register primitive.
// Build option: FLIP_FLOP_D_QN_EN adds the complemented output Qn.
package flip_flop_d_pkg;

    localparam int DEFAULT_WIDTH       = 1;
    localparam int DEFAULT_DEPTH       = 1;
    localparam int DEFAULT_RESET_VALUE = 0;

    // Qn is opt-in: a plain build exposes only clk, rst, en, D and Q.
`ifdef FLIP_FLOP_D_QN_EN
    localparam bit QN_ENABLED = 1'b1;
`else
    localparam bit QN_ENABLED = 1'b0;
`endif

endpackage

// File: rtl/flip_flop_d_stage.sv
// One WIDTH-bit register of the flip_flop_d chain: async reset to
// RESET_VALUE, load d when enabled, otherwise hold.
module flip_flop_d_stage
    import flip_flop_d_pkg::*;
#(
    parameter int              WIDTH       = DEFAULT_WIDTH,
    parameter logic [WIDTH-1:0] RESET_VALUE = WIDTH'(DEFAULT_RESET_VALUE)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    // Reset dominates the enable, so an enabled edge during reset still holds RESET_VALUE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q <= RESET_VALUE;
        end else if (en) begin
            q <= d;
        end
    end

endmodule

// File: rtl/flip_flop_d.sv
// Parameterizable D register: DEPTH cascaded WIDTH-bit stages sharing one
// enable and one asynchronous reset. Q is the last stage.
// Build option: FLIP_FLOP_D_QN_EN adds Qn = ~Q (combinational, no extra flop).
module flip_flop_d
    import flip_flop_d_pkg::*;
#(
    parameter int              WIDTH       = DEFAULT_WIDTH,
    parameter int              DEPTH       = DEFAULT_DEPTH,
    parameter logic [WIDTH-1:0] RESET_VALUE = WIDTH'(DEFAULT_RESET_VALUE)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [WIDTH-1:0] D,
    output logic [WIDTH-1:0] Q
`ifdef FLIP_FLOP_D_QN_EN
    ,
    output logic [WIDTH-1:0] Qn
`endif
);

    logic [WIDTH-1:0] stage_q [DEPTH];

    for (genvar i = 0; i < DEPTH; i++) begin : g_stage
        logic [WIDTH-1:0] stage_d;

        // The first stage takes the input; every later stage takes its predecessor.
        if (i == 0) begin : g_head
            assign stage_d = D;
        end else begin : g_tail
            assign stage_d = stage_q[i-1];
        end

        flip_flop_d_stage #(
            .WIDTH       (WIDTH),
            .RESET_VALUE (RESET_VALUE)
        ) u_stage (
            .clk (clk),
            .rst (rst),
            .en  (en),
            .d   (stage_d),
            .q   (stage_q[i])
        );
    end

    assign Q = stage_q[DEPTH-1];

`ifdef FLIP_FLOP_D_QN_EN
    // Derived from the last stage so it tracks Q through reset as well.
    assign Qn = ~stage_q[DEPTH-1];
`endif

endmodule

// File: tb/tb_flip_flop_d.sv
// Self-checking bench for flip_flop_d: directed scenarios on several
// parameterizations plus a randomized stream compared against a queue model.
`timescale 1ns/1ps
module tb_flip_flop_d;

    localparam int               WIDTH_R = 6;
    localparam int               DEPTH_R = 4;
    localparam logic [WIDTH_R-1:0] RV_R  = 6'h2B;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_total = 0;
    int n_bad   = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // A: default parameters
    logic rst_a, en_a;
    logic [0:0] d_a, q_a;
    flip_flop_d u_a (.clk(clk), .rst(rst_a), .en(en_a), .D(d_a), .Q(q_a)
`ifdef FLIP_FLOP_D_QN_EN
        , .Qn()
`endif
    );

    // B: 8-bit, reset value A5
    logic rst_b, en_b;
    logic [7:0] d_b, q_b;
    flip_flop_d #(.WIDTH(8), .RESET_VALUE(8'hA5)) u_b (.clk(clk), .rst(rst_b), .en(en_b), .D(d_b), .Q(q_b)
`ifdef FLIP_FLOP_D_QN_EN
        , .Qn()
`endif
    );

    // C: 4-bit, depth 3
    logic rst_c, en_c;
    logic [3:0] d_c, q_c;
    flip_flop_d #(.WIDTH(4), .DEPTH(3)) u_c (.clk(clk), .rst(rst_c), .en(en_c), .D(d_c), .Q(q_c)
`ifdef FLIP_FLOP_D_QN_EN
        , .Qn()
`endif
    );

    // D: 4-bit, reset value 0, complemented output when built in
    logic rst_d, en_d;
    logic [3:0] d_d, q_d;
`ifdef FLIP_FLOP_D_QN_EN
    logic [3:0] qn_d;
`endif
    flip_flop_d #(.WIDTH(4), .RESET_VALUE(4'h0)) u_d (.clk(clk), .rst(rst_d), .en(en_d), .D(d_d), .Q(q_d)
`ifdef FLIP_FLOP_D_QN_EN
        , .Qn(qn_d)
`endif
    );

    // R: randomized stream
    logic rst_r, en_r;
    logic [WIDTH_R-1:0] d_r, q_r;
    flip_flop_d #(.WIDTH(WIDTH_R), .DEPTH(DEPTH_R), .RESET_VALUE(RV_R)) u_r (.clk(clk), .rst(rst_r), .en(en_r), .D(d_r), .Q(q_r)
`ifdef FLIP_FLOP_D_QN_EN
        , .Qn()
`endif
    );

    // Model: Q is the sample taken DEPTH enabled edges ago since the last
    // reset, or the reset value if fewer than DEPTH samples exist.
    logic [WIDTH_R-1:0] hist[$];

    function automatic logic [WIDTH_R-1:0] model_q();
        if (hist.size() >= DEPTH_R) return hist[hist.size() - DEPTH_R];
        return RV_R;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_a = 1'b1; en_a = 1'b1; d_a = 1'b1;
        rst_b = 1'b1; en_b = 1'b0; d_b = '0;
        rst_c = 1'b1; en_c = 1'b0; d_c = '0;
        rst_d = 1'b1; en_d = 1'b0; d_d = '0;
        rst_r = 1'b1; en_r = 1'b0; d_r = '0;

        // A: directed waveform from time zero
        #1  chk("a_reset", 32'(q_a), 32'h0);
        #1  rst_a = 1'b0;
        #4  chk("a_edge5", 32'(q_a), 32'h1);
        #6  d_a = 1'b0;
        #4  chk("a_edge15", 32'(q_a), 32'h0);
        #8  d_a = 1'b1;
        #2  chk("a_edge25", 32'(q_a), 32'h1);
        #10 chk("a_edge35", 32'(q_a), 32'h1);
        d_a = 1'b0;
        #10 chk("a_edge45", 32'(q_a), 32'h0);

        // A: enable hold
        @(negedge clk) d_a = 1'b1;
        @(posedge clk) #1 chk("a_hold_pre", 32'(q_a), 32'h1);
        @(negedge clk) begin en_a = 1'b0; d_a = 1'b0; end
        repeat (3) begin
            @(posedge clk) #1 chk("a_hold", 32'(q_a), 32'h1);
        end
        @(negedge clk) en_a = 1'b1;
        @(posedge clk) #1 chk("a_hold_release", 32'(q_a), 32'h0);

        // A: reset and enable together across an edge
        @(negedge clk) begin d_a = 1'b1; en_a = 1'b1; rst_a = 1'b1; end
        #1 chk("a_simul_async", 32'(q_a), 32'h0);
        @(posedge clk) #1 chk("a_simul_edge", 32'(q_a), 32'h0);
        @(negedge clk) rst_a = 1'b0;

        // D: outputs during reset
        chk("d_reset_q", 32'(q_d), 32'h0);
`ifdef FLIP_FLOP_D_QN_EN
        chk("d_reset_qn", 32'(qn_d), 32'hF);
`endif
        rst_b = 1'b0; rst_c = 1'b0; rst_d = 1'b0;

        // B: reset in the middle of a stream
        @(negedge clk) begin en_b = 1'b1; d_b = 8'h3C; end
        @(posedge clk) #1 chk("b_load", 32'(q_b), 32'h3C);
        @(negedge clk) d_b = 8'h77;
        #2 rst_b = 1'b1;
        #1 chk("b_async", 32'(q_b), 32'hA5);
        @(posedge clk) #1 chk("b_reset_edge", 32'(q_b), 32'hA5);
        @(negedge clk) begin rst_b = 1'b0; en_b = 1'b0; end
        @(posedge clk) #1 chk("b_post_hold", 32'(q_b), 32'hA5);
        @(negedge clk) en_b = 1'b1;
        @(posedge clk) #1 chk("b_first_load", 32'(q_b), 32'h77);

        // C: latency of three stages
        @(negedge clk) begin en_c = 1'b1; d_c = 4'h1; end
        @(posedge clk) #1 chk("c_lat0", 32'(q_c), 32'h0);
        @(negedge clk) d_c = 4'h2;
        @(posedge clk) #1 chk("c_lat1", 32'(q_c), 32'h0);
        @(negedge clk) d_c = 4'h3;
        @(posedge clk) #1 chk("c_lat2", 32'(q_c), 32'h1);
        @(negedge clk) d_c = 4'h0;
        @(posedge clk) #1 chk("c_lat3", 32'(q_c), 32'h2);
        @(posedge clk) #1 chk("c_lat4", 32'(q_c), 32'h3);

        // D: load and complement
        @(negedge clk) begin en_d = 1'b1; d_d = 4'h6; end
        @(posedge clk) #1 chk("d_load_q", 32'(q_d), 32'h6);
`ifdef FLIP_FLOP_D_QN_EN
        chk("d_load_qn", 32'(qn_d), 32'h9);
`endif

        // R: randomized enable, data and async reset against the queue model
        hist.delete();
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            d_r   = WIDTH_R'($urandom);
            en_r  = ($urandom_range(0, 3) != 0);
            rst_r = ($urandom_range(0, 15) == 0);
            if (rst_r) begin
                hist.delete();
                #1 chk("r_async", 32'(q_r), 32'(RV_R));
            end
            @(posedge clk);
            if (!rst_r && en_r) hist.push_back(d_r);
            if (hist.size() > DEPTH_R) void'(hist.pop_front());
            #1 chk("r_stream", 32'(q_r), 32'(model_q()));
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
